// File: rtl/matrix_job_launcher.sv
// Matrix job launcher: validates a (row, column) job, programs the vector-size, matrix-size
// and run CSRs with setup/pulse/hold strobes, then tracks busy/idle and reports completion.
module matrix_job_launcher #(
    parameter int DATA_WIDTH   = 32,
    parameter int PE_NUMBER    = 64,
    parameter int VALID_WIDTH  = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_row_size,
    input  logic [7:0]            cmd_column_size,
    output logic                  vec_valid,
    output logic [DATA_WIDTH-1:0] vec_data,
    input  logic                  vec_ready,
    output logic                  mat_valid,
    output logic [DATA_WIDTH-1:0] mat_data,
    input  logic                  mat_ready,
    output logic                  csr_valid,
    output logic [DATA_WIDTH-1:0] csr_data,
    input  logic                  csr_ready,
    output logic                  done,
    output logic [1:0]            err
);
    localparam int CNT_MAX = (VALID_WIDTH > BUSY_TIMEOUT) ? VALID_WIDTH : BUSY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [8:0] PE_MAX = 9'(PE_NUMBER);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SETUP, S_PULSE, S_HOLD, S_WAIT_BUSY, S_WAIT_IDLE, S_DONE
    } state_e;

    // Which CSR write the shared SETUP/PULSE/HOLD sequence is currently serving.
    typedef enum logic [1:0] {P_VEC, P_MAT, P_RUN, P_DISARM} port_e;

    state_e                state_q, state_d;
    port_e                 port_q, port_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            row_q, row_d, col_q, col_d;
    logic [1:0]            code_q, code_d;
    logic                  vec_valid_q, vec_valid_d, mat_valid_q, mat_valid_d;
    logic                  csr_valid_q, csr_valid_d, done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] vec_data_q, vec_data_d, mat_data_q, mat_data_d;
    logic [DATA_WIDTH-1:0] csr_data_q, csr_data_d;
    logic                  bad_size;

    assign cmd_ready = (state_q == S_IDLE) && vec_ready && mat_ready && csr_ready;
    assign bad_size  = (cmd_row_size == 8'd0) || ({1'b0, cmd_row_size} > PE_MAX) ||
                       (cmd_column_size == 8'd0) || ({1'b0, cmd_column_size} > PE_MAX);

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        code_d     = code_q;
        vec_data_d = vec_data_q;
        mat_data_d = mat_data_q;
        csr_data_d = csr_data_q;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready) begin
                row_d   = cmd_row_size;
                col_d   = cmd_column_size;
                code_d  = bad_size ? 2'b01 : 2'b00;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (code_q != 2'b00) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_SETUP;
                    port_d     = P_VEC;
                    vec_data_d = DATA_WIDTH'(row_q);
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
            S_PULSE: begin
                if (cnt_q == CW'(VALID_WIDTH - 1)) state_d = S_HOLD;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            S_HOLD: begin
                case (port_q)
                    P_VEC: begin
                        state_d    = S_SETUP;
                        port_d     = P_MAT;
                        mat_data_d = DATA_WIDTH'(col_q);
                    end
                    P_MAT: begin
                        state_d    = S_SETUP;
                        port_d     = P_RUN;
                        csr_data_d = DATA_WIDTH'(1);
                    end
                    P_RUN: begin
                        state_d = S_WAIT_BUSY;
                        cnt_d   = '0;
                    end
                    default: state_d = S_WAIT_IDLE;
                endcase
            end
            S_WAIT_BUSY: begin
                // A busy indication wins over a timeout landing in the same cycle.
                if (!csr_ready || (cnt_q == CW'(BUSY_TIMEOUT - 1))) begin
                    if (csr_ready) code_d = 2'b10;
                    state_d    = S_SETUP;
                    port_d     = P_DISARM;
                    csr_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: if (csr_ready) state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                code_d  = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so they leave the flops glitch-free.
        vec_valid_d = (state_d == S_PULSE) && (port_d == P_VEC);
        mat_valid_d = (state_d == S_PULSE) && (port_d == P_MAT);
        csr_valid_d = (state_d == S_PULSE) && ((port_d == P_RUN) || (port_d == P_DISARM));
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_DONE) ? code_d : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            port_q      <= P_VEC;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            code_q      <= 2'b00;
            vec_valid_q <= 1'b0;
            mat_valid_q <= 1'b0;
            csr_valid_q <= 1'b0;
            vec_data_q  <= '0;
            mat_data_q  <= '0;
            csr_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            code_q      <= code_d;
            vec_valid_q <= vec_valid_d;
            mat_valid_q <= mat_valid_d;
            csr_valid_q <= csr_valid_d;
            vec_data_q  <= vec_data_d;
            mat_data_q  <= mat_data_d;
            csr_data_q  <= csr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign mat_valid = mat_valid_q;
    assign mat_data  = mat_data_q;
    assign csr_valid = csr_valid_q;
    assign csr_data  = csr_data_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_matrix_job_launcher.sv
// Bench for matrix_job_launcher: a per-job timeline model predicts every output of the main
// instance each cycle; VALID_WIDTH 1 and 3 instances are watched for pulse width and data stability.
module tb_matrix_job_launcher;
    localparam int DW = 32, PE = 64, VW = 2, BT = 16, W = VW + 2, MAXC = 1024;

    logic            clk = 1'b0, reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic [7:0]      cmd_row_size = '0, cmd_column_size = '0;
    logic            vec_ready = 1'b1, mat_ready = 1'b1, csr_ready = 1'b1;
    logic            cmd_ready, vec_valid, mat_valid, csr_valid, done;
    logic [DW-1:0]   vec_data, mat_data, csr_data;
    logic [1:0]      err;

    int cyc = 0, n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    // Expected timeline of the main instance, indexed by cycle (cycle c = interval after edge c).
    int e_v [3][MAXC];
    int e_d [3][MAXC];
    int e_done [MAXC];
    int e_err [MAXC];
    int e_idle [MAXC];
    bit prof [MAXC];

    // Monitor view of all three instances: index 0 -> VW 1, 1 -> VW 3, 2 -> main (VW 2).
    logic [2:0]    xv [3];
    logic [DW-1:0] xd [3][3];
    logic          xdn [3];
    logic [1:0]    xer [3];
    logic          xcr [3];
    bit            pv [3][3];
    logic [DW-1:0] pd [3][3];
    logic [DW-1:0] rd [3][3];
    int            wc [3][3];
    int            ndone [3];
    int            nerr [3];
    int            vwt [3] = '{1, 3, 2};

    matrix_job_launcher #(.DATA_WIDTH(DW), .PE_NUMBER(PE), .VALID_WIDTH(VW), .BUSY_TIMEOUT(BT)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row_size(cmd_row_size), .cmd_column_size(cmd_column_size),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
        .mat_valid(mat_valid), .mat_data(mat_data), .mat_ready(mat_ready),
        .csr_valid(csr_valid), .csr_data(csr_data), .csr_ready(csr_ready),
        .done(done), .err(err)
    );

    assign xv[2]    = {csr_valid, mat_valid, vec_valid};
    assign xd[2][0] = vec_data;
    assign xd[2][1] = mat_data;
    assign xd[2][2] = csr_data;
    assign xdn[2]   = done;
    assign xer[2]   = err;
    assign xcr[2]   = cmd_ready;

    for (genvar g = 0; g < 2; g++) begin : g_alt
        logic [2:0]    v;
        logic [DW-1:0] d0, d1, d2;
        logic          cr, dn;
        logic [1:0]    er;
        matrix_job_launcher #(.DATA_WIDTH(DW), .PE_NUMBER(PE), .VALID_WIDTH(g == 0 ? 1 : 3),
                              .BUSY_TIMEOUT(BT)) u_alt (
            .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr),
            .cmd_row_size(cmd_row_size), .cmd_column_size(cmd_column_size),
            .vec_valid(v[0]), .vec_data(d0), .vec_ready(vec_ready),
            .mat_valid(v[1]), .mat_data(d1), .mat_ready(mat_ready),
            .csr_valid(v[2]), .csr_data(d2), .csr_ready(csr_ready),
            .done(dn), .err(er)
        );
        assign xv[g]    = v;
        assign xd[g][0] = d0;
        assign xd[g][1] = d1;
        assign xd[g][2] = d2;
        assign xdn[g]   = dn;
        assign xer[g]   = er;
        assign xcr[g]   = cr;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        csr_ready = prof[cyc];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vec_valid", 32'(vec_valid), e_v[0][cyc]);
            chk("vec_data", vec_data, e_d[0][cyc]);
            chk("mat_valid", 32'(mat_valid), e_v[1][cyc]);
            chk("mat_data", mat_data, e_d[1][cyc]);
            chk("csr_valid", 32'(csr_valid), e_v[2][cyc]);
            chk("csr_data", csr_data, e_d[2][cyc]);
            chk("done", 32'(done), e_done[cyc]);
            chk("err", 32'(err), e_err[cyc]);
            chk("cmd_ready", 32'(cmd_ready),
                32'(e_idle[cyc] != 0 && vec_ready && mat_ready && csr_ready));
            for (int i = 0; i < 3; i++) begin
                if (!reset && xdn[i]) ndone[i]++;
                if (!reset && xer[i] != 2'b00) nerr[i]++;
                for (int p = 0; p < 3; p++) begin
                    if (reset) begin
                        pv[i][p] = 1'b0;
                        wc[i][p] = 0;
                    end else begin
                        if (xv[i][p] && !pv[i][p]) begin
                            chk($sformatf("i%0d_p%0d_setup_data", i, p), xd[i][p], pd[i][p]);
                            rd[i][p] = xd[i][p];
                            wc[i][p] = 1;
                        end else if (xv[i][p]) begin
                            chk($sformatf("i%0d_p%0d_pulse_data", i, p), xd[i][p], rd[i][p]);
                            wc[i][p]++;
                        end else if (pv[i][p]) begin
                            chk($sformatf("i%0d_p%0d_hold_data", i, p), xd[i][p], rd[i][p]);
                            chk($sformatf("i%0d_p%0d_pulse_width", i, p), wc[i][p], vwt[i]);
                        end
                        pv[i][p] = xv[i][p];
                    end
                    pd[i][p] = xd[i][p];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic model_write(input int p, input int s, input int d);
        for (int c = s; c < MAXC; c++) e_d[p][c] = d;
        for (int c = s + 1; c <= s + VW; c++) e_v[p][c] = 1;
    endtask

    task automatic model_reset(input int c);
        for (int k = c; k < MAXC; k++) begin
            for (int p = 0; p < 3; p++) begin
                e_v[p][k] = 0;
                e_d[p][k] = 0;
            end
            e_done[k] = 0;
            e_err[k]  = 0;
            e_idle[k] = 1;
        end
    endtask

    // Job accepted at edge t: writes of W cycles each back to back from t+1, then busy/idle tracking.
    task automatic model_job(input int t, input int row, input int col, output int dc);
        int s, e, c;
        bit to;
        if (row == 0 || row > PE || col == 0 || col > PE) begin
            dc = t + 1;
            e_err[dc] = 1;
        end else begin
            model_write(0, t + 1, row);
            model_write(1, t + 1 + W, col);
            model_write(2, t + 1 + 2 * W, 1);
            s  = t + 1 + 3 * W;
            e  = s;
            to = 1'b0;
            while (prof[e]) begin
                if (e - s + 1 == BT) begin
                    to = 1'b1;
                    break;
                end
                e++;
            end
            model_write(2, e + 1, 0);
            c = e + W + 1;
            while (!prof[c] && c < MAXC - 2) c++;
            dc = c + 1;
            e_err[dc] = to ? 2 : 0;
        end
        e_done[dc] = 1;
        for (int k = t; k <= dc; k++) e_idle[k] = 0;
    endtask

    task automatic launch(input int row, input int col, output int t, output int dc);
        cmd_valid       = 1'b1;
        cmd_row_size    = 8'(row);
        cmd_column_size = 8'(col);
        t = cyc + 1;
        model_job(t, row, col, dc);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int t, dc, c0;
        for (int k = 0; k < MAXC; k++) begin
            prof[k]   = 1'b1;
            e_idle[k] = 1;
        end
        step();
        step();
        chk("rst_vec_valid", 32'(vec_valid), 0);
        chk("rst_csr_data", csr_data, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_alt_cmd_ready", 32'(xcr[0] && xcr[1]), 1);
        reset  = 1'b0;
        chk_en = 1'b1;
        step();

        // Nominal (3,4): busy T+13..T+22; a stray command during the job must be ignored.
        for (int k = 13; k < 23; k++) prof[cyc + 1 + k] = 1'b0;
        launch(3, 4, t, dc);
        cmd_valid = 1'b1; cmd_row_size = 8'd9; cmd_column_size = 8'd9;
        go_to(t + 1);  chk("nom_vec_data", vec_data, 3);
        go_to(t + 2);  chk("nom_vec_rise", 32'(vec_valid), 1);
        go_to(t + 3);  cmd_valid = 1'b0;
        go_to(t + 4);  chk("nom_vec_hold", 32'(vec_valid), 0);
        go_to(t + 5);  chk("nom_mat_data", mat_data, 4);
        go_to(t + 10); chk("nom_run_pulse", {31'd0, csr_valid} | (csr_data << 1), 3);
        go_to(t + 15); chk("nom_disarm_pulse", {31'd0, csr_valid} | (csr_data << 1), 1);
        go_to(t + 24); chk("nom_done", {30'd0, err} | {31'd0, done} << 4, 32'h10);
        go_to(t + 60);

        // Ready gating, then illegal sizes.
        cmd_valid = 1'b1; cmd_row_size = 8'd1; cmd_column_size = 8'd1; vec_ready = 1'b0;
        step();
        vec_ready = 1'b1; mat_ready = 1'b0;
        step();
        mat_ready = 1'b1; cmd_valid = 1'b0;
        step();
        launch(0, 4, t, dc);
        go_to(t + 1); chk("ill0_done_err", {30'd0, err} | {31'd0, done} << 4, 32'h11);
        go_to(t + 4);
        launch(3, 65, t, dc);
        go_to(t + 1); chk("ill65_done_err", {30'd0, err} | {31'd0, done} << 4, 32'h11);
        go_to(t + 6);

        // Timeout at the largest legal size: csr_ready never falls.
        launch(64, 64, t, dc);
        go_to(t + 30); chk("to_disarm_pulse", {31'd0, csr_valid} | (csr_data << 1), 1);
        go_to(t + 34); chk("to_done_err", {30'd0, err} | {31'd0, done} << 4, 32'h12);
        go_to(t + 60);

        // Back-pressure: csr_ready low for 5 cycles while the command is offered.
        c0 = cyc;
        for (int k = 1; k <= 5; k++) prof[c0 + k] = 1'b0;
        for (int k = 13; k < 23; k++) prof[c0 + 7 + k] = 1'b0;
        step();
        cmd_valid = 1'b1; cmd_row_size = 8'd5; cmd_column_size = 8'd7;
        go_to(c0 + 3); #2; chk("bp_cmd_ready_low", 32'(cmd_ready), 0);
        go_to(c0 + 6); #2; chk("bp_cmd_ready_rise", 32'(cmd_ready), 1);
        t = c0 + 7;
        model_job(t, 5, 7, dc);
        step();
        cmd_valid = 1'b0;
        go_to(t + 1); chk("bp_vec_data", vec_data, 5);
        go_to(t + 60);

        // Reset while mat_valid is high, then a fresh job.
        for (int k = 13; k < 23; k++) prof[cyc + 1 + k] = 1'b0;
        launch(2, 5, t, dc);
        go_to(t + 6); chk("rm_mat_valid_pre", 32'(mat_valid), 1);
        #1;
        reset = 1'b1;
        model_reset(cyc);
        #1;
        chk("rm_mat_valid_async", 32'(mat_valid), 0);
        chk("rm_vec_data_async", vec_data, 0);
        step();
        step();
        reset = 1'b0;
        go_to(t + 30);
        for (int k = 13; k < 23; k++) prof[cyc + 1 + k] = 1'b0;
        launch(2, 2, t, dc);
        go_to(t + 1);  chk("post_vec_data", vec_data, 2);
        go_to(t + 24); chk("post_done", {30'd0, err} | {31'd0, done} << 4, 32'h10);
        go_to(t + 60);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d_done_count", i), ndone[i], 6);
            chk($sformatf("i%0d_err_count", i), nerr[i], 3);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
